draw_pair_writer: RTL and testbench

Downstream consumer of the draw-path address-pair counter. Accepts even/odd framebuffer address pairs plus two pixel values per pair over a valid/ready handshake. Buffers pairs in a small FIFO and commits each pair to the dual-port framebuffer RAM on ports A and B in the same cycle. Tracks a configured frame-segment length and signals completion.

---
 rtl/draw_pkg.sv | 21 ++
 rtl/draw_pair_writer_fifo.sv | 66 ++++++
 rtl/draw_pair_writer.sv | 166 ++++++++++++++++
 tb/tb_draw_pair_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types for the draw-path pair writer.
// State encoding, default widths and the buffered pair record.
package draw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 8;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr_a;
      logic [ADDR_W_DEF-1:0] addr_b;
      logic [DATA_W_DEF-1:0] data_a;
      logic [DATA_W_DEF-1:0] data_b;
   } pixel_pair_t;

endpackage

// File: rtl/draw_pair_writer_fifo.sv
// Small synchronous FIFO of address/pixel pairs.
// Head entry is visible on dout whenever the FIFO is not empty.
module pair_fifo
   import draw_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = pixel_pair_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/draw_pair_writer.sv
// Buffers even/odd address pairs and commits each pair
// to the dual-port framebuffer on ports A and B together.
module draw_pair_writer
   import draw_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_PAIRS  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr_a,
   input  logic [ADDR_W-1:0] in_addr_b,
   input  logic [DATA_W-1:0] in_data_a,
   input  logic [DATA_W-1:0] in_data_b,
   input  logic              mem_ready,
   output logic              we_a,
   output logic              we_b,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] wdata_a,
   output logic [DATA_W-1:0] wdata_b,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(NUM_PAIRS + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_PAIRS);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_PAIRS - 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr_a;
      logic [ADDR_W-1:0] addr_b;
      logic [DATA_W-1:0] data_a;
      logic [DATA_W-1:0] data_b;
   } pair_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [DATA_W-1:0] wdata_a_q, wdata_a_d;
   logic [DATA_W-1:0] wdata_b_q, wdata_b_d;

   pair_t             in_pair;
   pair_t             head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              well_formed;
   logic              push;
   logic              pop;

   assign in_pair     = '{in_addr_a, in_addr_b, in_data_a, in_data_b};
   assign in_ready    = (state_q == RUN) && !fifo_full;
   assign accept      = in_valid && in_ready;
   assign well_formed = !in_addr_a[0]
                     && (in_addr_b == (in_addr_a | ADDR_W'(1)));
   assign push        = accept && well_formed;
   assign pop         = !fifo_empty && mem_ready
                     && (state_q != IDLE);

   pair_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (pair_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (in_pair),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Run control: start, pair counting, error capture, drain exit.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         RUN: begin
            if (accept) begin
               if (!well_formed) err_d = 1'b1;
               if (count_q != CNT_MAX) count_d = count_q + CW'(1);
               if (count_q == CNT_LAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && !we_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Write port: load the FIFO head on pop, otherwise hold.
   always_comb begin
      we_d      = pop;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      wdata_a_d = wdata_a_q;
      wdata_b_d = wdata_b_q;
      if (pop) begin
         addr_a_d  = head.addr_a;
         addr_b_d  = head.addr_b;
         wdata_a_d = head.data_a;
         wdata_b_d = head.data_b;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         wdata_a_q <= '0;
         wdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         err_q     <= err_d;
         done_q    <= done_d;
         we_q      <= we_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         wdata_a_q <= wdata_a_d;
         wdata_b_q <= wdata_b_d;
      end
   end

   assign we_a    = we_q;
   assign we_b    = we_q;
   assign addr_a  = addr_a_q;
   assign addr_b  = addr_b_q;
   assign wdata_a = wdata_a_q;
   assign wdata_b = wdata_b_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_draw_pair_writer.sv
// Scoreboard bench for draw_pair_writer.
// Accepted pairs are queued; each RAM write pops and compares.
module tb_draw_pair_writer;

   localparam int AW = 14;
   localparam int DW = 8;
   localparam int NP = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr_a, in_addr_b;
   logic [DW-1:0] in_data_a, in_data_b;
   logic          mem_ready;
   logic          we_a, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic          busy, done, err;

   draw_pair_writer #(
      .ADDR_W(AW), .DATA_W(DW),
      .FIFO_DEPTH(4), .NUM_PAIRS(NP)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr_a(in_addr_a), .in_addr_b(in_addr_b),
      .in_data_a(in_data_a), .in_data_b(in_data_b),
      .mem_ready(mem_ready),
      .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int acc_n, bad_n, wr_n, done_n = 0, done0;
   int first_acc, first_wr;
   logic [2*AW+2*DW-1:0] exp_q[$];

   task automatic chk(input string tag,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every RAM write must match the oldest queued pair.
   always @(negedge clk) begin
      if (reset) begin
         chk("we_eq", we_b, we_a);
         if (we_a) begin
            wr_n++;
            if (first_wr < 0) first_wr = cyc;
            if (exp_q.size() == 0) chk("wr_extra", 1, 0);
            else chk("wr_pair", {addr_a, addr_b, wdata_a, wdata_b},
                     exp_q.pop_front());
         end
         if (done) done_n++;
      end
   end

   task automatic step(output bit acc);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
         acc_n++;
         if (first_acc < 0) first_acc = cyc;
         if (!in_addr_a[0] && in_addr_b == (in_addr_a | 14'd1))
            exp_q.push_back({in_addr_a, in_addr_b, in_data_a, in_data_b});
         else bad_n++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_pair(input int i);
      in_addr_a = AW'(2048 + 2 * i);
      in_addr_b = AW'(2049 + 2 * i);
      in_data_a = DW'(i * 3);
      in_data_b = DW'(i) ^ 8'h5a;
   endtask

   task automatic offer_raw(input logic [AW-1:0] a,
                            input logic [AW-1:0] b,
                            input logic [DW-1:0] da,
                            input logic [DW-1:0] db);
      bit acc = 0;
      in_addr_a = a; in_addr_b = b;
      in_data_a = da; in_data_b = db;
      in_valid = 1'b1;
      for (int n = 0; n < 100 && !acc; n++) step(acc);
      if (!acc) chk("offer_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic offer(input int i);
      bit acc = 0;
      set_pair(i);
      in_valid = 1'b1;
      for (int n = 0; n < 100 && !acc; n++) step(acc);
      if (!acc) chk("offer_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic stream(input int n, input int base);
      for (int i = 0; i < n; i++) offer(base + i);
   endtask

   task automatic begin_run();
      acc_n = 0; bad_n = 0; wr_n = 0;
      first_acc = -1; first_wr = -1;
      done0 = done_n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_run", busy, 1);
   endtask

   task automatic end_run(input logic exp_err);
      int n = 0;
      @(negedge clk);
      chk("rdy_drain", in_ready, 0);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
      chk("busy_done", busy, 0);
      chk("err_done", err, exp_err);
      chk("q_empty", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", done_n - done0, 1);
      chk("wr_cnt", wr_n, acc_n - bad_n);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || we_a) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      bit acc;
      int i, k;
      first_wr = -1;
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      set_pair(0);
      #3;
      chk("rst_we_a", we_a, 0);
      chk("rst_we_b", we_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rdy", in_ready, 0);
      chk("rst_addr", {addr_a, addr_b}, 0);
      chk("rst_data", {wdata_a, wdata_b}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_rdy", in_ready, 0);

      // nominal run
      begin_run();
      stream(NP, 0);
      chk("first_lat", first_wr - first_acc, 2);
      end_run(1'b0);

      // backpressure, full FIFO, malformed pair, ignored start
      begin_run();
      stream(2, 0);
      wait_drain();
      mem_ready = 1'b0;
      i = 2; k = 0;
      set_pair(i);
      in_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         step(acc);
         if (!acc) break;
         k++; i++;
         set_pair(i);
      end
      chk("fill_acc", k, 4);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rdy_full", in_ready, 0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      step(acc);
      chk("acc_after_pop", acc, 1);
      i++;
      set_pair(i);
      @(negedge clk);
      chk("rdy_refull", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      mem_ready = 1'b1;
      offer_raw(14'd2051, 14'd2052, 8'hc3, 8'h3c);
      chk("err_set", err, 1);
      offer_raw(14'd2052, 14'd2053, 8'ha5, 8'h5a);
      start = 1'b1;
      offer(i);
      start = 1'b0;
      i++;
      chk("busy_start", busy, 1);
      while (acc_n < NP) begin
         offer(i);
         i++;
      end
      end_run(1'b1);

      // reset in the middle of a run
      begin_run();
      stream(50, 0);
      chk("we_pre_rst", we_a, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_we_a", we_a, 0);
      chk("rst_mid_we_b", we_b, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rdy", in_ready, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      begin_run();
      chk("err_fresh", err, 0);
      stream(NP, 5);
      end_run(1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
